pipe_reg_elastic: RTL and testbench

Parametrised successor to the plain 32-bit clocked register. It is a DEPTH-stage elastic pipeline register with a valid/ready handshake, bubble collapsing, synchronous flush and an occupancy count. It sits between multi-cycle CPU datapath stages, for example IR/MDR/ALUOut staging, where stalls and flushes are needed.

---
 rtl/pipe_reg_elastic.sv | 111 +++++++++++
 tb/tb_pipe_reg_elastic.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_elastic.sv
// DEPTH-stage elastic pipeline register: valid/ready handshake, bubble collapsing, sync flush, occupancy.
// Latency DEPTH cycles; backpressure ripples combinationally from out_ready; `PIPE_REG_STALL_CNT_EN adds stall_cnt.
module pipe_reg_elastic #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              OCC_W     = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [OCC_W-1:0] occupancy
`ifdef PIPE_REG_STALL_CNT_EN
   ,
   output logic [31:0]      stall_cnt
`endif
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_nxt;
   logic [DEPTH-1:0] rdy;
   logic [DEPTH-1:0] ld;
   logic [OCC_W-1:0] occ_nxt;

   // A stage can take a new word if it is empty or anything downstream of it can move.
   always_comb begin
      logic r;
      rdy = '0;
      r   = out_ready;
      for (int k = DEPTH-1; k >= 0; k--) begin
         r      = !v_q[k] || r;
         rdy[k] = r;
      end
   end

   always_comb begin
      v_nxt = v_q;
      ld    = '0;
      if (flush) begin
         v_nxt = '0;
      end else begin
         if (rdy[0]) begin
            v_nxt[0] = in_valid;
            ld[0]    = in_valid;
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k]) begin
               v_nxt[k] = v_q[k-1];
               ld[k]    = v_q[k-1];
            end
         end
      end
   end

   always_comb begin
      occ_nxt = '0;
      for (int k = 0; k < DEPTH; k++) begin
         occ_nxt = occ_nxt + OCC_W'(v_nxt[k]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q       <= '0;
         occupancy <= '0;
      end else begin
         v_q       <= v_nxt;
         occupancy <= occ_nxt;
      end
   end

   // Data only moves on a valid transfer; flushed stages keep stale data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            data_q[k] <= RESET_VAL;
         end
      end else begin
         if (ld[0]) begin
            data_q[0] <= in_data;
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (ld[k]) begin
               data_q[k] <= data_q[k-1];
            end
         end
      end
   end

   assign in_ready  = rdy[0] && !flush;
   assign out_valid = v_q[DEPTH-1] && !flush;
   assign out_data  = data_q[DEPTH-1];

`ifdef PIPE_REG_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic (WIDTH=32, DEPTH=3): queue-of-words model with per-word stage position.
module tb_pipe_reg_elastic;

   localparam int WIDTH = 32;
   localparam int DEPTH = 3;
   localparam logic [31:0] RV = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
`ifdef PIPE_REG_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   pipe_reg_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
`ifdef PIPE_REG_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: in-flight words in order, each with the stage it currently sits in.
   logic [31:0] m_dat [$];
   int          m_pos [$];
   logic [31:0] m_stall = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_dat.delete();
         m_pos.delete();
         m_stall = '0;
      end else if (flush) begin
         m_dat.delete();
         m_pos.delete();
      end else begin
         bit acc;
         acc = in_valid && ((m_dat.size() < DEPTH) || out_ready);
         if (m_pos.size() > 0 && m_pos[0] == DEPTH-1 && !out_ready && m_stall != 32'hFFFF_FFFF)
            m_stall = m_stall + 32'd1;
         // A word moves on if the sink drains or a free slot exists ahead of it.
         for (int i = 0; i < m_pos.size(); i++) begin
            if (out_ready || (i < DEPTH-1-m_pos[i])) m_pos[i] = m_pos[i] + 1;
         end
         if (m_pos.size() > 0 && m_pos[0] == DEPTH) begin
            void'(m_pos.pop_front());
            void'(m_dat.pop_front());
         end
         if (acc) begin
            m_dat.push_back(in_data);
            m_pos.push_back(0);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         int sz;
         bit mv;
         sz = m_dat.size();
         mv = (sz > 0) && (m_pos[0] == DEPTH-1) && !flush;
         check("in_ready", 32'(in_ready), 32'(((sz < DEPTH) || out_ready) && !flush));
         check("out_valid", 32'(out_valid), 32'(mv));
         check("occupancy", 32'(occupancy), 32'(sz));
         if (mv) check("out_data", out_data, m_dat[0]);
`ifdef PIPE_REG_STALL_CNT_EN
         check("stall_cnt", stall_cnt, m_stall);
`endif
      end
   end

   task automatic drive(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #2;
   endtask

   initial begin
      flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
      #1 rst = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'hDEADBEEF);
      check("rst_occ", 32'(occupancy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      chk_en = 1'b1;
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;

      // Streaming
      drive(1, 32'h11, 1, 0);
      drive(1, 32'h22, 1, 0);
      drive(1, 32'h33, 1, 0);
      check("stream_first", out_data, 32'h11);
      check("stream_first_vld", 32'(out_valid), 32'd1);
      check("stream_occ", 32'(occupancy), 32'd3);
      drive(1, 32'h44, 1, 0);
      check("stream_second", out_data, 32'h22);
      check("stream_occ2", 32'(occupancy), 32'd3);
      repeat (3) drive(0, 32'h0, 1, 0);
      check("stream_drained", 32'(occupancy), 32'd0);

      // Full stall
      drive(1, 32'hA0, 0, 0);
      drive(1, 32'hA1, 0, 0);
      drive(1, 32'hA2, 0, 0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_occ", 32'(occupancy), 32'd3);
      repeat (2) drive(1, 32'hA3, 0, 0);
      check("stall_hold_occ", 32'(occupancy), 32'd3);
      check("stall_hold_data", out_data, 32'hA0);
      drive(1, 32'hA3, 1, 0);
      check("release_data", out_data, 32'hA1);
      drive(0, 32'h0, 1, 0);
      check("release_data2", out_data, 32'hA2);
      drive(0, 32'h0, 1, 0);
      check("release_data3", out_data, 32'hA3);
      drive(0, 32'h0, 1, 0);
      check("release_drained", 32'(occupancy), 32'd0);

      // Bubble collapse
      drive(1, 32'h01, 0, 0);
      drive(0, 32'h0, 0, 0);
      drive(1, 32'h02, 0, 0);
      drive(0, 32'h0, 0, 0);
      check("bubble_occ", 32'(occupancy), 32'd2);
      check("bubble_in_ready", 32'(in_ready), 32'd1);
      check("bubble_head", out_data, 32'h01);
      repeat (3) drive(0, 32'h0, 1, 0);

      // Flush with simultaneous traffic
      drive(1, 32'hB0, 0, 0);
      drive(1, 32'hB1, 0, 0);
      drive(1, 32'hB2, 0, 0);
      check("pre_flush_occ", 32'(occupancy), 32'd3);
      in_valid = 1; in_data = 32'h55; out_ready = 1; flush = 1;
      #1;
      check("flush_in_ready", 32'(in_ready), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #2;
      flush = 0;
      #1;
      check("post_flush_occ", 32'(occupancy), 32'd0);
      check("post_flush_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #2;
      in_valid = 0;
      check("accept_55_occ", 32'(occupancy), 32'd1);
      repeat (2) drive(0, 32'h0, 1, 0);
      check("out_55", out_data, 32'h55);
      drive(0, 32'h0, 1, 0);

      // Reset mid-operation, asserted between edges
      drive(1, 32'hD0, 0, 0);
      drive(1, 32'hD1, 0, 0);
      in_valid = 0;
      #1 rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", out_data, 32'hDEADBEEF);
      check("midrst_occ", 32'(occupancy), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #2;
      rst = 1'b0;

`ifdef PIPE_REG_STALL_CNT_EN
      check("scnt_after_rst", stall_cnt, 32'd0);
      drive(1, 32'hC0, 0, 0);
      repeat (2) drive(0, 32'h0, 0, 0);
      check("scnt_pre", stall_cnt, 32'd0);
      repeat (10) drive(0, 32'h0, 0, 0);
      check("scnt_10", stall_cnt, 32'd10);
      drive(0, 32'h0, 0, 1);
      check("scnt_flush", stall_cnt, 32'd10);
      #1 rst = 1'b1;
      #1;
      check("scnt_rst", stall_cnt, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
`endif

      repeat (2) drive(0, 32'h0, 1, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
